// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file writeback controller.
// Holds the default widths, the writeback requester enum and the writeback record.
package regfile_ctrl_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // The enum value doubles as the bit index into the arbiter valid/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input writeback arbiter producing a one-hot grant.
// WB_RR_ARB_EN selects round-robin tie-breaking; otherwise MEM has fixed priority.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic mem_wins;

`ifdef WB_RR_ARB_EN
    req_e last_grant;

    // A grant always completes its handshake, so the grant itself advances the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ_ALU;
        end else if (grant[REQ_MEM]) begin
            last_grant <= REQ_MEM;
        end else if (grant[REQ_ALU]) begin
            last_grant <= REQ_ALU;
        end
    end

    assign mem_wins = (last_grant == REQ_ALU);
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clock & reset_n;
    assign mem_wins       = 1'b1;
`endif

    always_comb begin
        grant = 2'b00;
        if (valid[REQ_MEM] && (!valid[REQ_ALU] || mem_wins)) begin
            grant[REQ_MEM] = 1'b1;
        end else if (valid[REQ_ALU]) begin
            grant[REQ_ALU] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/load writebacks and keeps the
// pending-write scoreboard used to stall issue. Tie policy set by WB_RR_ARB_EN.
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
)
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [ADDR_W-1:0]    iss_rd,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    output logic                 stall,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_wa,
    output logic [DATA_W-1:0]    rf_wd,
    output logic [2**ADDR_W-1:0] busy
);

    logic [1:0]          valid;
    logic [1:0]          grant;
    logic                alu_acc;
    logic                mem_acc;
    logic                iss_acc;
    logic                wb_acc;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;
    logic [2**ADDR_W-1:0] busy_next;

    assign valid = {mem_valid, alu_valid};

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (valid),
        .grant   (grant)
    );

    // Readies are forced low while reset is held so nothing is accepted into a cleared pipe.
    assign alu_ready = reset_n & grant[REQ_ALU];
    assign mem_ready = reset_n & grant[REQ_MEM];
    assign alu_acc   = alu_valid & alu_ready;
    assign mem_acc   = mem_valid & mem_ready;
    assign wb_acc    = alu_acc | mem_acc;

    assign win_rd   = mem_acc ? mem_rd   : alu_rd;
    assign win_data = mem_acc ? mem_data : alu_data;

    assign stall     = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);
    assign iss_ready = reset_n & ~busy[iss_rd] & ~stall;
    assign iss_acc   = iss_valid & iss_ready;

    // A writeback to x0 still occupies its slot but never asserts the write enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= wb_acc && (win_rd != '0);
            if (wb_acc) begin
                rf_wa <= win_rd;
                rf_wd <= win_data;
            end
        end
    end

    // Clear is applied before set so a same-edge issue to the written register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_wa] = 1'b0;
        end
        if (iss_acc && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a per-cycle reference model plus directed
// scenarios with literal expectations. Honours WB_RR_ARB_EN for tie expectations.
module tb_regfile_wb_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock;
    logic          reset_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          iss_valid;
    logic          iss_ready;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [NR-1:0] busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    regfile_wb_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pending flags per register, the one expected write slot, last winner.
    bit            m_busy [NR];
    bit            m_we   = 1'b0;
    wb_rec_t       m_wr   = '0;
    req_e          m_last = REQ_ALU;
    logic          mem_wins;
    logic          exp_alu_rdy;
    logic          exp_mem_rdy;
    logic          exp_stall;
    logic          exp_iss_rdy;
    logic [NR-1:0] m_busy_vec;

    always_comb begin
        mem_wins = 1'b1;
`ifdef WB_RR_ARB_EN
        mem_wins = (m_last == REQ_ALU);
`endif
        exp_mem_rdy = reset_n && mem_valid && (!alu_valid || mem_wins);
        exp_alu_rdy = reset_n && alu_valid && !(mem_valid && mem_wins);
        exp_stall   = ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]);
        exp_iss_rdy = reset_n && !m_busy[iss_rd] && !exp_stall;
        m_busy_vec  = '0;
        for (int i = 0; i < NR; i++) m_busy_vec[i] = m_busy[i];
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_busy[i] <= 1'b0;
            m_we   <= 1'b0;
            m_wr   <= '0;
            m_last <= REQ_ALU;
        end else begin
            if (m_we) m_busy[m_wr.rd] <= 1'b0;
            if (iss_valid && exp_iss_rdy && (iss_rd != 0)) m_busy[iss_rd] <= 1'b1;
            if (exp_mem_rdy) begin
                m_we   <= (mem_rd != 0);
                m_wr   <= '{rd: mem_rd, data: mem_data};
                m_last <= REQ_MEM;
            end else if (exp_alu_rdy) begin
                m_we   <= (alu_rd != 0);
                m_wr   <= '{rd: alu_rd, data: alu_data};
                m_last <= REQ_ALU;
            end else begin
                m_we   <= 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check_output("alu_ready", alu_ready, exp_alu_rdy);
            check_output("mem_ready", mem_ready, exp_mem_rdy);
            check_output("iss_ready", iss_ready, exp_iss_rdy);
            check_output("stall", stall, exp_stall);
            check_output("rf_we", rf_we, m_we);
            check_output("busy", busy, m_busy_vec);
            if (m_we || !reset_n) begin
                check_output("rf_wa", rf_wa, m_wr.rd);
                check_output("rf_wd", rf_wd, m_wr.data);
            end
        end
    end

    task automatic apply_stimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic exp_mem_tie;

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        #1 cmp_en = 1'b1;

        // Held in reset with a writeback offered: nothing may be accepted.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        repeat (2) apply_stimulus();
        settle();
        check_output("lit_reset_alu_ready", alu_ready, 1'b0);
        check_output("lit_reset_rf_we", rf_we, 1'b0);
        check_output("lit_reset_busy", busy, 32'h0);
        apply_stimulus();
        reset_n = 1'b1;
        settle();
        check_output("lit_release_alu_ready", alu_ready, 1'b1);
        apply_stimulus();
        alu_valid = 1'b0;
        settle();
        check_output("lit_first_rf_we", rf_we, 1'b1);
        check_output("lit_first_rf_wa", rf_wa, 5'd3);
        check_output("lit_first_rf_wd", rf_wd, 32'h33);

        // Issue to x5, then the ALU writes it back while rs1 watches it.
        apply_stimulus();
        iss_valid = 1'b1; iss_rd = 5'd5;
        settle();
        check_output("lit_iss5_ready", iss_ready, 1'b1);
        apply_stimulus();
        iss_valid = 1'b0; rs1 = 5'd5;
        settle();
        check_output("lit_busy5_set", busy[5], 1'b1);
        check_output("lit_stall_rs1_5", stall, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        apply_stimulus();
        alu_valid = 1'b0;
        settle();
        check_output("lit_wb5_rf_wa", rf_wa, 5'd5);
        check_output("lit_wb5_rf_wd", rf_wd, 32'hDEADBEEF);
        check_output("lit_busy5_held", busy[5], 1'b1);
        check_output("lit_stall_held", stall, 1'b1);
        apply_stimulus();
        settle();
        check_output("lit_busy5_clear", busy[5], 1'b0);
        check_output("lit_stall_clear", stall, 1'b0);
        rs1 = 5'd0;

        // Four tied cycles; the last grant before this was the ALU.
        apply_stimulus();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifdef WB_RR_ARB_EN
            exp_mem_tie = ((i % 2) == 0);
`else
            exp_mem_tie = 1'b1;
`endif
            check_output("lit_tie_mem_ready", mem_ready, exp_mem_tie);
            check_output("lit_tie_alu_ready", alu_ready, !exp_mem_tie);
            apply_stimulus();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        settle();
`ifdef WB_RR_ARB_EN
        check_output("lit_tie_last_wa", rf_wa, 5'd1);
`else
        check_output("lit_tie_last_wa", rf_wa, 5'd2);
`endif

        // x0 writeback and x0 issue.
        apply_stimulus();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        settle();
        check_output("lit_x0_mem_ready", mem_ready, 1'b1);
        apply_stimulus();
        mem_valid = 1'b0;
        settle();
        check_output("lit_x0_rf_we", rf_we, 1'b0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        settle();
        check_output("lit_x0_iss_ready", iss_ready, 1'b1);
        apply_stimulus();
        iss_valid = 1'b0;
        settle();
        check_output("lit_x0_busy", busy, 32'h0);

        // Issue to a busy x7 while its write lands is refused.
        apply_stimulus();
        iss_valid = 1'b1; iss_rd = 5'd7;
        settle();
        check_output("lit_iss7_ready", iss_ready, 1'b1);
        apply_stimulus();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        apply_stimulus();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        settle();
        check_output("lit_iss7_blocked", iss_ready, 1'b0);
        check_output("lit_wb7_rf_wa", rf_wa, 5'd7);
        apply_stimulus();
        iss_valid = 1'b0;
        settle();
        check_output("lit_busy7_clear", busy[7], 1'b0);

        // Unscoreboarded write to x7 lands on the same edge as a new issue to x7.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        apply_stimulus();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        settle();
        check_output("lit_same_edge_iss_ready", iss_ready, 1'b1);
        check_output("lit_same_edge_rf_we", rf_we, 1'b1);
        apply_stimulus();
        iss_valid = 1'b0;
        settle();
        check_output("lit_set_wins", busy[7], 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h79;
        apply_stimulus();
        alu_valid = 1'b0;
        apply_stimulus();
        settle();
        check_output("lit_busy7_final", busy[7], 1'b0);

        // Reset in the middle of a live write with registers pending.
        iss_valid = 1'b1; iss_rd = 5'd10;
        apply_stimulus();
        iss_rd = 5'd9;
        apply_stimulus();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        apply_stimulus();
        alu_valid = 1'b0;
        settle();
        check_output("lit_pre_reset_rf_we", rf_we, 1'b1);
        check_output("lit_pre_reset_busy", busy, 32'h600);
        reset_n = 1'b0;
        #1;
        check_output("lit_async_rf_we", rf_we, 1'b0);
        check_output("lit_async_busy", busy, 32'h0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3C;
        #1;
        check_output("lit_async_alu_ready", alu_ready, 1'b0);
        repeat (2) apply_stimulus();
        reset_n = 1'b1;
        apply_stimulus();
        alu_valid = 1'b0;
        settle();
        check_output("lit_post_reset_rf_we", rf_we, 1'b1);
        check_output("lit_post_reset_rf_wa", rf_wa, 5'd3);
        check_output("lit_post_reset_rf_wd", rf_wd, 32'h3C);
        repeat (2) apply_stimulus();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
